rbm_seq_layer: RTL and testbench

Time-multiplexed, parametrised RBM visible-to-hidden sampling layer. It computes h_j = sample(sigmoid(sum_i v_i·W[i][j] + b_j)) for OUT_DIM hidden units, using one MAC per hidden unit that iterates over the IN_DIM inputs. The layer replaces the fully combinational multiply/add path with a start/done transaction, saturating fixed-point arithmetic, per-unit LFSRs that advance once per transaction, and a deterministic threshold mode. It sits between the weight/bias store and the Gibbs-chain controller.

---
 rtl/rbm_seq_layer.sv | 184 ++++++++++++++++++
 tb/tb_rbm_seq_layer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbm_seq_layer.sv
// Time-multiplexed RBM visible-to-hidden sampling layer: one MAC per hidden unit,
// saturating fixed point, PLAN sigmoid, per-unit Galois LFSR sampling. Optional ProbO port via RBM_PROB_OUT_EN.
module rbm_seq_layer #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned FRAC      = 4,
    parameter int unsigned SG_W      = 8,
    parameter int unsigned IN_DIM    = 6,
    parameter int unsigned OUT_DIM   = 5,
    parameter logic [15:0] SEED_BASE = 16'hACE1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               StartI,
    input  logic                               ModeI,
    input  logic [IN_DIM*DATA_W-1:0]           ImageI,
    input  logic [IN_DIM*OUT_DIM*DATA_W-1:0]   WeightI,
    input  logic [OUT_DIM*DATA_W-1:0]          BiasI,
    output logic                               BusyO,
    output logic                               DoneO,
    output logic [OUT_DIM-1:0]                 HoutputO
`ifdef RBM_PROB_OUT_EN
    ,
    output logic [OUT_DIM*SG_W-1:0]            ProbO
`endif
);

    localparam int unsigned IDX_W  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(IN_DIM) + 1;
    localparam int unsigned XS_W   = DATA_W + SG_W + 1;

    localparam logic signed [ACC_W-1:0] PRE_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] PRE_MIN = ~PRE_MAX;
    localparam logic [15:0]             LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ACT,
        S_SAMPLE
    } state_t;

    state_t                   state;
    logic                     mode_q;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc  [OUT_DIM];
    logic [SG_W-1:0]          prob [OUT_DIM];
    logic [15:0]              lfsr [OUT_DIM];

    logic signed [DATA_W-1:0] v_cur;
    logic signed [DATA_W-1:0] w_cur    [OUT_DIM];
    logic signed [DATA_W-1:0] b_cur    [OUT_DIM];
    logic signed [PROD_W-1:0] prod_c   [OUT_DIM];
    logic signed [ACC_W-1:0]  prod_ext [OUT_DIM];
    logic signed [ACC_W-1:0]  bias_ext [OUT_DIM];
    logic [SG_W-1:0]          prob_c   [OUT_DIM];
    logic [OUT_DIM-1:0]       h_c;

    // Arithmetic shift back to DATA_W fractional format, clamped to the signed DATA_W range
    function automatic logic signed [DATA_W-1:0] sat_pre(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> FRAC;
        if (sh > PRE_MAX)
            return DATA_W'(PRE_MAX);
        else if (sh < PRE_MIN)
            return DATA_W'(PRE_MIN);
        else
            return DATA_W'(sh);
    endfunction

    // PLAN piecewise-linear sigmoid; result in units of 2^-SG_W, 1.0 clamps to all ones
    function automatic logic [SG_W-1:0] sigmoid(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] ax;
        logic [XS_W-1:0]   xs;
        logic [XS_W-1:0]   y;
        ax = x[DATA_W-1] ? DATA_W'(-x) : DATA_W'(x);
        xs = (XS_W'(ax) << SG_W) >> FRAC;
        if (ax >= DATA_W'(5 << FRAC))
            y = XS_W'(1 << SG_W);
        else if (ax >= DATA_W'((19 << FRAC) >> 3))
            y = (xs >> 5) + XS_W'((27 << SG_W) >> 5);
        else if (ax >= DATA_W'(1 << FRAC))
            y = (xs >> 3) + XS_W'((5 << SG_W) >> 3);
        else
            y = (xs >> 2) + XS_W'(1 << (SG_W - 1));
        if (x[DATA_W-1])
            return SG_W'(XS_W'(1 << SG_W) - y);
        else if (y >= XS_W'(1 << SG_W))
            return {SG_W{1'b1}};
        else
            return SG_W'(y);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [15:0] seed_of(input int unsigned j);
        logic [15:0] s;
        s = SEED_BASE ^ 16'(j * 32'h0000_9E37);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    // Datapath: current-index products, bias preload and per-unit decisions
    always_comb begin
        v_cur = signed'(ImageI[int'(idx)*DATA_W +: DATA_W]);
        h_c   = '0;
        for (int j = 0; j < OUT_DIM; j++) begin
            w_cur[j]    = signed'(WeightI[(int'(idx)*OUT_DIM + j)*DATA_W +: DATA_W]);
            b_cur[j]    = signed'(BiasI[j*DATA_W +: DATA_W]);
            prod_c[j]   = PROD_W'(v_cur) * PROD_W'(w_cur[j]);
            prod_ext[j] = ACC_W'(prod_c[j]);
            bias_ext[j] = ACC_W'(b_cur[j]) <<< FRAC;
            prob_c[j]   = sigmoid(sat_pre(acc[j]));
            if (mode_q)
                h_c[j] = (prob[j] >= SG_W'(1 << (SG_W - 1)));
            else
                h_c[j] = (prob[j] > lfsr[j][15 -: SG_W]);
        end
    end

    // Sequencer: IDLE -> MAC (IN_DIM cycles) -> ACT -> SAMPLE -> IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            mode_q   <= 1'b0;
            idx      <= '0;
            BusyO    <= 1'b0;
            DoneO    <= 1'b0;
            HoutputO <= '0;
`ifdef RBM_PROB_OUT_EN
            ProbO    <= '0;
`endif
            for (int j = 0; j < OUT_DIM; j++) begin
                acc[j]  <= '0;
                prob[j] <= '0;
                lfsr[j] <= seed_of(j);
            end
        end else begin
            DoneO <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (StartI) begin
                        mode_q <= ModeI;
                        idx    <= '0;
                        BusyO  <= 1'b1;
                        for (int j = 0; j < OUT_DIM; j++)
                            acc[j] <= bias_ext[j];
                        state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    for (int j = 0; j < OUT_DIM; j++)
                        acc[j] <= acc[j] + prod_ext[j];
                    if (idx == IDX_W'(IN_DIM - 1)) begin
                        idx   <= '0;
                        state <= S_ACT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_ACT: begin
                    for (int j = 0; j < OUT_DIM; j++)
                        prob[j] <= prob_c[j];
                    state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    HoutputO <= h_c;
                    DoneO    <= 1'b1;
                    BusyO    <= 1'b0;
                    for (int j = 0; j < OUT_DIM; j++) begin
                        lfsr[j] <= lfsr_next(lfsr[j]);
`ifdef RBM_PROB_OUT_EN
                        ProbO[j*SG_W +: SG_W] <= prob[j];
`endif
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rbm_seq_layer.sv
// Scoreboard bench for rbm_seq_layer: stimulus pushes expected HoutputO, a forked monitor
// pops and compares on every DoneO. Build with +define+RBM_PROB_OUT_EN to also check ProbO.
module tb_rbm_seq_layer;

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned SG_W    = 8;
    localparam int unsigned IN_DIM  = 6;
    localparam int unsigned OUT_DIM = 5;

    logic                             clock = 1'b0;
    logic                             reset;
    logic                             StartI;
    logic                             ModeI;
    logic [IN_DIM*DATA_W-1:0]         ImageI;
    logic [IN_DIM*OUT_DIM*DATA_W-1:0] WeightI;
    logic [OUT_DIM*DATA_W-1:0]        BiasI;
    logic                             BusyO;
    logic                             DoneO;
    logic [OUT_DIM-1:0]               HoutputO;
`ifdef RBM_PROB_OUT_EN
    logic [OUT_DIM*SG_W-1:0]          ProbO;
`endif

    int checks = 0;
    int errors = 0;
    logic [OUT_DIM-1:0] exp_q [$];
    logic [15:0]        lfsr_m [OUT_DIM];
    logic [OUT_DIM-1:0] seq_rec [256];

    rbm_seq_layer dut (
        .clock    (clock),
        .reset    (reset),
        .StartI   (StartI),
        .ModeI    (ModeI),
        .ImageI   (ImageI),
        .WeightI  (WeightI),
        .BiasI    (BiasI),
        .BusyO    (BusyO),
        .DoneO    (DoneO),
        .HoutputO (HoutputO)
`ifdef RBM_PROB_OUT_EN
        ,
        .ProbO    (ProbO)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (DoneO) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got HoutputO=%b want no DoneO", HoutputO);
                end else begin
                    chk("hout", 32'(HoutputO), 32'(exp_q.pop_front()));
                end
            end
        end
    endtask

    function automatic logic [15:0] model_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic model_reset();
        logic [15:0] s;
        for (int j = 0; j < OUT_DIM; j++) begin
            s = 16'hACE1 ^ 16'(j * 32'h0000_9E37);
            lfsr_m[j] = (s == 16'h0000) ? 16'h0001 : s;
        end
    endtask

    task automatic model_step();
        for (int j = 0; j < OUT_DIM; j++)
            lfsr_m[j] = model_next(lfsr_m[j]);
    endtask

    // With p = 0.5 on every unit, h_j = 1 exactly when the LFSR top byte is below 128
    function automatic logic [OUT_DIM-1:0] lfsr_expect();
        logic [OUT_DIM-1:0] e;
        for (int j = 0; j < OUT_DIM; j++)
            e[j] = ~lfsr_m[j][15];
        return e;
    endfunction

    task automatic set_data(input int vv, input int ww, input int bb);
        for (int i = 0; i < IN_DIM; i++)
            ImageI[i*DATA_W +: DATA_W] = DATA_W'(vv);
        for (int k = 0; k < IN_DIM*OUT_DIM; k++)
            WeightI[k*DATA_W +: DATA_W] = DATA_W'(ww);
        for (int j = 0; j < OUT_DIM; j++)
            BiasI[j*DATA_W +: DATA_W] = DATA_W'(bb);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!DoneO && n < 40);
        if (!DoneO) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got no DoneO want DoneO within 40 cycles");
        end
    endtask

    task automatic run_txn(input logic mode, input logic [OUT_DIM-1:0] exp_det);
        int n;
        @(negedge clock);
        ModeI  = mode;
        StartI = 1'b1;
        @(negedge clock);
        StartI = 1'b0;
        exp_q.push_back(mode ? exp_det : lfsr_expect());
        model_step();
        wait_done(n);
        chk("latency", 32'(n), 32'd8);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset  = 1'b1;
        StartI = 1'b1;
        @(negedge clock);
        reset  = 1'b0;
        StartI = 1'b0;
        model_reset();
        chk("rst_busy", 32'(BusyO), 32'd0);
        chk("rst_hout", 32'(HoutputO), 32'd0);
        @(negedge clock);
        chk("rst_start_dropped", 32'(BusyO), 32'd0);
    endtask

    initial begin
        int bl [OUT_DIM] = '{0, -1, 1, -16, 16};
        int gap;
        int ones;
        reset   = 1'b1;
        StartI  = 1'b0;
        ModeI   = 1'b0;
        ImageI  = '0;
        WeightI = '0;
        BiasI   = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_reset();
        chk("reset_busy", 32'(BusyO), 32'd0);
        chk("reset_done", 32'(DoneO), 32'd0);
        chk("reset_hout", 32'(HoutputO), 32'd0);
`ifdef RBM_PROB_OUT_EN
        chk("reset_prob", 32'(ProbO), 32'd0);
`endif

        // Deterministic: sum 6.0 -> all ones, negated weights -> all zeros
        set_data(16, 16, 0);
        run_txn(1'b1, 5'b11111);
        set_data(16, -16, 0);
        run_txn(1'b1, 5'b00000);

        // Threshold boundary: pre = b_j, p(0) = 0.5 counts as 1, p(-1/16) does not
        set_data(0, 0, 0);
        for (int j = 0; j < OUT_DIM; j++)
            BiasI[j*DATA_W +: DATA_W] = DATA_W'(bl[j]);
        run_txn(1'b1, 5'b10101);

        // Saturation to both rails without wrap-around
        set_data(2047, 2047, 2047);
        run_txn(1'b1, 5'b11111);
        set_data(2047, -2048, 2047);
        run_txn(1'b1, 5'b00000);

        // Latency and BusyO window, with a StartI pulse mid-transaction that must be ignored
        set_data(0, 0, 0);
        @(negedge clock);
        ModeI  = 1'b1;
        StartI = 1'b1;
        @(posedge clock);
        exp_q.push_back(5'b11111);
        model_step();
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            StartI = (c == 3);
            chk($sformatf("busy_c%0d", c), 32'(BusyO), 32'((c <= 8) ? 1 : 0));
            chk($sformatf("done_c%0d", c), 32'(DoneO), 32'((c == 9) ? 1 : 0));
`ifdef RBM_PROB_OUT_EN
            if (c == 9)
                for (int j = 0; j < OUT_DIM; j++)
                    chk($sformatf("prob_sig0_%0d", j), 32'(ProbO[j*SG_W +: SG_W]), 32'd128);
`endif
        end

        // Back-to-back: StartI held across DoneO re-accepts at once
        set_data(16, 16, 0);
        @(negedge clock);
        ModeI  = 1'b1;
        StartI = 1'b1;
        exp_q.push_back(5'b11111);
        exp_q.push_back(5'b11111);
        model_step();
        model_step();
        wait_done(gap);
        gap = 0;
        do begin
            @(negedge clock);
            gap++;
            if (gap == 1)
                StartI = 1'b0;
        end while (!DoneO && gap < 40);
        chk("b2b_gap", 32'(gap), 32'd9);

        // Reset in the middle of MAC: no DoneO, outputs cleared, LFSRs reseeded
        set_data(0, 0, 0);
        @(negedge clock);
        ModeI  = 1'b0;
        StartI = 1'b1;
        @(negedge clock);
        StartI = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        chk("abort_busy", 32'(BusyO), 32'd0);
        chk("abort_hout", 32'(HoutputO), 32'd0);
        chk("abort_done", 32'(DoneO), 32'd0);
        repeat (12) @(negedge clock);
        run_txn(1'b0, 5'b00000);

        // Stochastic: p = 0.5, 256 transactions, then identical replay after reset
        do_reset();
        ones = 0;
        for (int n = 0; n < 256; n++) begin
            run_txn(1'b0, 5'b00000);
            seq_rec[n] = HoutputO;
            ones += int'(HoutputO[0]);
        end
        checks++;
        if (ones < 96 || ones > 160) begin
            errors++;
            $display("FAIL h0_ones got %0d want 96..160", ones);
        end
        do_reset();
        for (int n = 0; n < 256; n++) begin
            run_txn(1'b0, 5'b00000);
            chk($sformatf("replay_%0d", n), 32'(HoutputO), 32'(seq_rec[n]));
        end

        repeat (4) @(negedge clock);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
